// File: rtl/fp_mul_rr_scheduler_if.sv
// Requester-side bus of fp_mul_rr_scheduler: operand handshake and tagged response.
// master = requesters, slave = scheduler.
interface fp_mul_rr_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/fp_mul_rr_scheduler.sv
// fp_mul_rr_scheduler: shares one float multiplier between NUM_REQ requesters.
// Define FP_MUL_SCHED_FIXED_PRIO_EN for fixed lowest-index priority (default: round-robin).
module fp_mul_rr_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int M          = 23,
  parameter int E          = 8,
  parameter int NUM_REQ    = 2,
  parameter int LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  fp_mul_rr_scheduler_if.slave     bus,
  output logic [DATA_WIDTH-1:0]    mul_in1,
  output logic [DATA_WIDTH-1:0]    mul_in2,
  input  logic [DATA_WIDTH-1:0]    mul_out,
  output logic [$clog2(LAT+1)-1:0] inflight
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LAT+1);

  if (1 + E + M != DATA_WIDTH) begin : g_fmt_chk
    $error("DATA_WIDTH must equal 1+E+M");
  end

  logic [NUM_REQ-1:0]    gnt;
  logic [IW-1:0]         gnt_idx;
  logic [IW-1:0]         cand;
  logic                  found;
  logic                  acc;
  logic                  v0;
  logic [IW-1:0]         t0;
  logic                  last_v;
  logic [IW-1:0]         last_t;
  logic [DATA_WIDTH-1:0] last_d;

`ifndef FP_MUL_SCHED_FIXED_PRIO_EN
  logic [IW-1:0] ptr;
`endif

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FP_MUL_SCHED_FIXED_PRIO_EN
      cand = IW'(k);
`else
      cand = IW'((int'(ptr) + k) % NUM_REQ);
`endif
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign acc = found & ~flush;

  always_comb begin
    gnt = '0;
    if (acc) gnt[gnt_idx] = 1'b1;
  end

  assign bus.req_ready = gnt;

`ifndef FP_MUL_SCHED_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (acc) begin
      ptr <= (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);
    end
  end
`endif

  // operand regs only load on accept so the multiplier inputs stay quiet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0      <= 1'b0;
      t0      <= '0;
      mul_in1 <= '0;
      mul_in2 <= '0;
    end else begin
      v0 <= acc;
      if (acc) begin
        t0      <= gnt_idx;
        mul_in1 <= bus.req_a[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
        mul_in2 <= bus.req_b[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  if (LAT == 1) begin : g_lat1
    assign last_v = v0;
    assign last_t = t0;
    assign last_d = v0 ? mul_out : '0;
  end else begin : g_pipe
    logic [LAT-1:1]        vs;
    logic [IW-1:0]         ts [LAT-1:1];
    logic [DATA_WIDTH-1:0] ds [LAT-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vs <= '0;
        for (int s = 1; s < LAT; s++) begin
          ts[s] <= '0;
          ds[s] <= '0;
        end
      end else begin
        vs[1] <= v0 & ~flush;
        if (v0) begin
          ts[1] <= t0;
          ds[1] <= mul_out;
        end
        for (int s = 2; s < LAT; s++) begin
          vs[s] <= vs[s-1] & ~flush;
          if (vs[s-1]) begin
            ts[s] <= ts[s-1];
            ds[s] <= ds[s-1];
          end
        end
      end
    end

    assign last_v = vs[LAT-1];
    assign last_t = ts[LAT-1];
    assign last_d = ds[LAT-1];
  end

  always_comb begin
    bus.rsp_valid = '0;
    if (last_v) bus.rsp_valid[last_t] = 1'b1;
  end

  assign bus.rsp_data = last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= '0;
    end else if (acc && !last_v) begin
      inflight <= inflight + CW'(1);
    end else if (!acc && last_v) begin
      inflight <= inflight - CW'(1);
    end
  end
endmodule
